// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the hex shift-register sequencer: mode codes and FSM states.
package shift_seq_ctrl_pkg;

  localparam logic [1:0] MODE_CLR   = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    S_INIT   = 2'b00,
    S_IDLE   = 2'b01,
    S_SCROLL = 2'b10
  } state_t;

  // Shift mode for a given direction: 0 = left, 1 = right.
  function automatic logic [1:0] dir_mode(input logic dir);
    return dir ? MODE_RIGHT : MODE_LEFT;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_scroll_prescaler.sv
// Auto-scroll prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
module shift_seq_ctrl_scroll_prescaler #(
  parameter int DIV = 50_000_000,
  parameter int W   = 26
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [W-1:0] L_TERM = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == L_TERM);

  // Count while enabled, wrap at terminal count; clear has priority over counting.
  always_ff @(posedge Clk) begin
    if (Rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the 8-digit hex shift register: turns keypad entries, clear
// requests and auto-scroll into registered Mode/Data/Step commands.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int SCROLL_DIV = 50_000_000,
  parameter int DIV_W      = 26
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Key_Valid,
  input  logic [3:0] Key_Data,
  input  logic       Dir,
  input  logic       Clr_Req,
  input  logic       Scroll_En,
  input  logic [3:0] Msd_In,
  input  logic [3:0] Lsd_In,
  output logic [1:0] Mode,
  output logic [3:0] Data,
  output logic       Step,
  output logic [3:0] Count
);

  localparam logic [3:0] L_DEPTH = 4'(DEPTH);

  state_t     r_state;
  logic [1:0] r_mode;
  logic [3:0] r_data;
  logic       r_step;
  logic [3:0] r_count;

  logic       w_tick;
  logic       w_pre_clr;
  logic       w_pre_en;

  // Prescaler only runs in SCROLL with scroll still requested; any clear or
  // key restarts the scroll interval.
  assign w_pre_en  = (r_state == S_SCROLL) && Scroll_En;
  assign w_pre_clr = Clr_Req || Key_Valid || (r_state != S_SCROLL);

  shift_seq_ctrl_scroll_prescaler #(
    .DIV (SCROLL_DIV),
    .W   (DIV_W)
  ) u_prescaler (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_clr  (w_pre_clr),
    .i_en   (w_pre_en),
    .o_tick (w_tick)
  );

  // Command FSM: priority clear > key > scroll tick; losers are dropped.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_INIT;
      r_mode  <= MODE_CLR;
      r_data  <= 4'h0;
      r_step  <= 1'b0;
      r_count <= 4'h0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        S_INIT: begin
          // Resync clear so the register matches Count=0 after reset.
          r_step  <= 1'b1;
          r_mode  <= MODE_CLR;
          r_data  <= 4'h0;
          r_count <= 4'h0;
          r_state <= S_IDLE;
        end
        S_IDLE, S_SCROLL: begin
          if (Clr_Req) begin
            r_step  <= 1'b1;
            r_mode  <= MODE_CLR;
            r_data  <= 4'h0;
            r_count <= 4'h0;
            r_state <= S_IDLE;
          end else begin
            if (Key_Valid) begin
              r_step  <= 1'b1;
              r_mode  <= dir_mode(Dir);
              r_data  <= Key_Data;
              r_count <= (r_count < L_DEPTH) ? r_count + 4'h1 : L_DEPTH;
            end else if (w_tick) begin
              // Rotate: the digit falling off one end re-enters at the other.
              r_step <= 1'b1;
              r_mode <= dir_mode(Dir);
              r_data <= Dir ? Lsd_In : Msd_In;
            end
            if (r_state == S_IDLE) begin
              if (Scroll_En && (r_count != 4'h0)) r_state <= S_SCROLL;
            end else if (!Scroll_En) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign Mode  = r_mode;
  assign Data  = r_data;
  assign Step  = r_step;
  assign Count = r_count;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a short scroll period (SCROLL_DIV=4).
module tb_shift_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Key_Valid;
  logic [3:0] Key_Data;
  logic       Dir;
  logic       Clr_Req;
  logic       Scroll_En;
  logic [3:0] Msd_In;
  logic [3:0] Lsd_In;
  logic [1:0] Mode;
  logic [3:0] Data;
  logic       Step;
  logic [3:0] Count;

  int n_tests = 0;
  int n_fail  = 0;

  shift_seq_ctrl #(
    .DEPTH      (8),
    .SCROLL_DIV (4),
    .DIV_W      (3)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Key_Valid (Key_Valid),
    .Key_Data  (Key_Data),
    .Dir       (Dir),
    .Clr_Req   (Clr_Req),
    .Scroll_En (Scroll_En),
    .Msd_In    (Msd_In),
    .Lsd_In    (Lsd_In),
    .Mode      (Mode),
    .Data      (Data),
    .Step      (Step),
    .Count     (Count)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic step, input logic [1:0] mode,
                           input logic [3:0] data, input logic [3:0] count);
    check_eq({tag, ".step"},  32'(Step),  32'(step));
    check_eq({tag, ".mode"},  32'(Mode),  32'(mode));
    check_eq({tag, ".data"},  32'(Data),  32'(data));
    check_eq({tag, ".count"}, 32'(Count), 32'(count));
  endtask

  int         steps;
  logic [3:0] exp_cnt;

  initial begin
    Rst = 1'b1; Key_Valid = 1'b0; Key_Data = 4'h0; Dir = 1'b0;
    Clr_Req = 1'b0; Scroll_En = 1'b0; Msd_In = 4'h0; Lsd_In = 4'h0;

    // 1. reset, then INIT clear step
    repeat (3) cyc();
    check_out("rst", 1'b0, 2'b00, 4'h0, 4'h0);
    Rst = 1'b0;
    cyc();
    check_out("init_clr", 1'b1, 2'b00, 4'h0, 4'h0);
    cyc();
    check_out("post_init", 1'b0, 2'b00, 4'h0, 4'h0);

    // 2. three back-to-back left keys
    Dir = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      Key_Valid = 1'b1; Key_Data = 4'(i);
      cyc();
      check_out($sformatf("key_l%0d", i), 1'b1, 2'b01, 4'(i), 4'(i));
    end
    Key_Valid = 1'b0;
    cyc();
    check_out("key_l_hold", 1'b0, 2'b01, 4'h3, 4'h3);

    // 3. clear, then 9 right keys: Count saturates at 8, 9th still steps
    Clr_Req = 1'b1;
    cyc();
    check_out("clr3", 1'b1, 2'b00, 4'h0, 4'h0);
    Clr_Req = 1'b0;
    Dir = 1'b1;
    for (int i = 0; i < 9; i++) begin
      Key_Valid = 1'b1; Key_Data = 4'(i + 5);
      cyc();
      exp_cnt = (i + 1 > 8) ? 4'd8 : 4'(i + 1);
      check_out($sformatf("key_r%0d", i), 1'b1, 2'b10, 4'(i + 5), exp_cnt);
    end
    Key_Valid = 1'b0;
    cyc();
    check_out("key_r_hold", 1'b0, 2'b10, 4'hD, 4'h8);

    // 4. scroll with Count=2, Msd_In=A, period 4
    Clr_Req = 1'b1;
    cyc();
    Clr_Req = 1'b0;
    Dir = 1'b0;
    Key_Valid = 1'b1; Key_Data = 4'h1; cyc();
    Key_Data = 4'h2; cyc();
    Key_Valid = 1'b0;
    check_eq("scr.count_pre", 32'(Count), 32'd2);
    Msd_In = 4'hA; Lsd_In = 4'h5; Scroll_En = 1'b1;
    steps = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check_eq($sformatf("scr.step%0d", k), 32'(Step), ((k == 5) || (k == 9)) ? 32'd1 : 32'd0);
      if (Step) begin
        steps++;
        check_eq($sformatf("scr.mode%0d", k), 32'(Mode), 32'h1);
        check_eq($sformatf("scr.data%0d", k), 32'(Data), 32'hA);
      end
    end
    check_eq("scr.nsteps", 32'(steps), 32'd2);
    check_eq("scr.count", 32'(Count), 32'd2);
    Scroll_En = 1'b0;
    steps = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (Step) steps++;
    end
    check_eq("scr_off.nsteps", 32'(steps), 32'd0);

    // 5. clear and key together: clear wins, scroll stays off at Count=0
    Clr_Req = 1'b1; Key_Valid = 1'b1; Key_Data = 4'h5;
    cyc();
    check_out("clr_key", 1'b1, 2'b00, 4'h0, 4'h0);
    Clr_Req = 1'b0; Key_Valid = 1'b0; Scroll_En = 1'b1;
    steps = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (Step) steps++;
    end
    check_eq("cnt0_noscroll.nsteps", 32'(steps), 32'd0);
    Scroll_En = 1'b0;
    cyc();

    // 6. reset during SCROLL
    Key_Valid = 1'b1; Key_Data = 4'h7;
    cyc();
    check_out("pre_rst_key", 1'b1, 2'b01, 4'h7, 4'h1);
    Key_Valid = 1'b0; Scroll_En = 1'b1;
    repeat (3) cyc();
    Rst = 1'b1;
    cyc();
    check_out("mid_rst", 1'b0, 2'b00, 4'h0, 4'h0);
    Rst = 1'b0; Scroll_En = 1'b0;
    cyc();
    check_out("mid_rst_init", 1'b1, 2'b00, 4'h0, 4'h0);
    cyc();
    check_out("mid_rst_idle", 1'b0, 2'b00, 4'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
